// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch stage.
// Fetches one word per instruction and holds it for decode until acknowledged.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ack,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   input  logic        branch_taken,
   input  logic [31:0] imm_ext,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_addr,
   output logic        misalign
);

   // Handshakes: a request transfers on a cycle with imem_req_valid && imem_req_ready;
   // a response is taken only while waiting for one; decode consumes on instr_valid && instr_ack.
   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] next_pc;
   logic        accept_ack;
   logic        unused_imm;

   assign accept_ack     = (state == HOLD) && instr_ack;
   assign pc_plus4       = pc + 32'd4;
   assign imem_req_valid = (state == REQ);
   assign imem_req_addr  = pc;
   assign instr_valid    = (state == HOLD);

   // The branch offset is a word offset; its top two bits fall off the shift.
   assign unused_imm = &{1'b0, imm_ext[31:30]};

   always_comb begin
      next_pc = pc_plus4;
      if (jr) begin
         next_pc = {jr_addr[31:2], 2'b00};
      end else if (jump) begin
         next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      end else if (branch_taken) begin
         next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: state_next = REQ;
         REQ:  if (imem_req_ready) state_next = WAIT;
         WAIT: if (imem_rsp_valid) state_next = HOLD;
         HOLD: if (instr_ack) state_next = REQ;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         instr    <= 32'h0000_0000;
         misalign <= 1'b0;
      end else begin
         state    <= state_next;
         misalign <= accept_ack && jr && (jr_addr[1:0] != 2'b00);
         if ((state == WAIT) && imem_rsp_valid) begin
            instr <= imem_rsp_data;
         end
         if (accept_ack) begin
            pc <= next_pc;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a driver plays memory and decode,
// a negedge monitor pops hand-computed expectations from queues.
module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ack = 1'b0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        branch_taken = 1'b0;
   logic [31:0] imm_ext = 32'h0;
   logic        jump = 1'b0;
   logic [25:0] jump_index = 26'h0;
   logic        jr = 1'b0;
   logic [31:0] jr_addr = 32'h0;
   logic        misalign;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } hold_t;

   logic [31:0] exp_q[$];
   hold_t       exp_hold_q[$];
   logic        exp_mis_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .instr(instr), .instr_valid(instr_valid),
      .instr_ack(instr_ack), .pc(pc), .pc_plus4(pc_plus4),
      .branch_taken(branch_taken), .imm_ext(imm_ext), .jump(jump),
      .jump_index(jump_index), .jr(jr), .jr_addr(jr_addr), .misalign(misalign)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " req_valid"}, {31'h0, imem_req_valid}, 32'h0);
      check({tag, " req_addr"}, imem_req_addr, RESET_PC);
      check({tag, " instr"}, instr, 32'h0);
      check({tag, " instr_valid"}, {31'h0, instr_valid}, 32'h0);
      check({tag, " pc"}, pc, RESET_PC);
      check({tag, " pc_plus4"}, pc_plus4, RESET_PC + 32'd4);
      check({tag, " misalign"}, {31'h0, misalign}, 32'h0);
   endtask

   task automatic wait_for_req();
      int n = 0;
      while (!imem_req_valid && n < 20) begin
         step();
         n++;
      end
      if (!imem_req_valid) begin
         checks++;
         errors++;
         $display("FAIL req timeout: got no request expected imem_req_valid within 20 cycles");
      end
   endtask

   // driver: one full fetch, then acknowledge with the given next-PC controls
   task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int rdelay,
                        input bit rsp_with_ready, input bit spurious, input int hold,
                        input bit a_jr, input bit a_jump, input bit a_br,
                        input logic [31:0] a_imm, input logic [25:0] a_idx,
                        input logic [31:0] a_jra, input bit exp_mis);
      exp_q.push_back(addr);
      wait_for_req();
      for (int i = 0; i < rdelay; i++) begin
         instr_ack = spurious;
         jr        = spurious;
         jr_addr   = 32'h0000_0003;
         step();
      end
      instr_ack = 1'b0;
      jr        = 1'b0;
      jr_addr   = 32'h0;
      imem_req_ready = 1'b1;
      if (rsp_with_ready) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
      step();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      exp_hold_q.push_back('{instr: data, pc: addr});
      step();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      repeat (hold) step();
      instr_ack    = 1'b1;
      jr           = a_jr;
      jump         = a_jump;
      branch_taken = a_br;
      imm_ext      = a_imm;
      jump_index   = a_idx;
      jr_addr      = a_jra;
      exp_mis_q.push_back(exp_mis);
      step();
      instr_ack    = 1'b0;
      jr           = 1'b0;
      jump         = 1'b0;
      branch_taken = 1'b0;
      imm_ext      = 32'h0;
      jump_index   = 26'h0;
      jr_addr      = 32'h0;
   endtask

   task automatic req_only(input logic [31:0] addr);
      exp_q.push_back(addr);
      wait_for_req();
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      repeat (3) step();
   endtask

   // scoreboard monitor
   logic        prev_req_valid = 1'b0;
   logic        prev_req_ready = 1'b0;
   logic        prev_instr_valid = 1'b0;
   logic        prev_ack = 1'b0;
   logic [31:0] prev_addr = 32'h0;
   logic [31:0] prev_instr = 32'h0;
   logic [31:0] prev_pc = 32'h0;
   int          hs_cyc = 0;
   int          ack_cyc = 0;
   bit          have_hs = 1'b0;
   bit          have_ack = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prev_req_valid   = 1'b0;
         prev_req_ready   = 1'b0;
         prev_instr_valid = 1'b0;
         prev_ack         = 1'b0;
         have_hs          = 1'b0;
         have_ack         = 1'b0;
      end else begin
         if (imem_req_valid && prev_req_valid && !prev_req_ready)
            check("req_addr stable", imem_req_addr, prev_addr);
         if (imem_req_valid && !prev_req_valid && have_ack) begin
            check("ack to next req latency", cyc - ack_cyc, 32'd1);
            have_ack = 1'b0;
         end
         if (imem_req_valid && imem_req_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected request addr", imem_req_addr, 32'hXXXX_XXXX);
            end else begin
               check("req_addr", imem_req_addr, exp_q.pop_front());
            end
            hs_cyc  = cyc;
            have_hs = 1'b1;
         end
         if (instr_valid && !prev_instr_valid) begin
            if (exp_hold_q.size() == 0) begin
               check("unexpected instr", instr, 32'hXXXX_XXXX);
            end else begin
               hold_t h;
               h = exp_hold_q.pop_front();
               check("instr", instr, h.instr);
               check("pc", pc, h.pc);
               check("pc_plus4", pc_plus4, h.pc + 32'd4);
            end
            if (have_hs) check("ready to instr_valid latency", cyc - hs_cyc, 32'd2);
            have_hs = 1'b0;
         end else if (instr_valid && prev_instr_valid) begin
            check("instr stable in hold", instr, prev_instr);
            check("pc stable in hold", pc, prev_pc);
         end
         if (prev_ack) begin
            if (exp_mis_q.size() == 0) begin
               check("unexpected ack", {31'h0, misalign}, 32'hXXXX_XXXX);
            end else begin
               check("misalign after ack", {31'h0, misalign}, {31'h0, exp_mis_q.pop_front()});
            end
         end else begin
            check("misalign idle", {31'h0, misalign}, 32'h0);
         end
         prev_ack = instr_valid && instr_ack;
         if (prev_ack) begin
            ack_cyc  = cyc;
            have_ack = 1'b1;
         end
         prev_req_valid   = imem_req_valid;
         prev_req_ready   = imem_req_ready;
         prev_addr        = imem_req_addr;
         prev_instr_valid = instr_valid;
         prev_instr       = instr;
         prev_pc          = pc;
      end
   end

   // stimulus: addr, data, rdelay, rsp_with_ready, spurious, hold, jr, jump, br, imm, idx, jr_addr, mis
   initial begin
      repeat (2) @(posedge clk);
      #3;
      check_reset_state("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      fetch(32'h0000_0000, 32'h2008_0005, 0, 0, 0, 0, 0, 0, 1, 32'h0000_003F, 26'h0, 32'h0, 0);
      fetch(32'h0000_0100, 32'h1000_FFFE, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFE, 26'h0, 32'h0, 0);
      fetch(32'h0000_00FC, 32'h03E0_0008, 0, 1, 0, 0, 1, 0, 0, 32'h0, 26'h0, 32'h0040_0010, 0);
      fetch(32'h0040_0010, 32'h0810_0004, 0, 0, 0, 0, 0, 1, 0, 32'h0, 26'h010_0004, 32'h0, 0);
      fetch(32'h0040_0010, 32'h0000_0001, 0, 0, 0, 0, 1, 1, 1, 32'h0000_0010, 26'h155, 32'h0000_2003, 1);
      fetch(32'h0000_2000, 32'h0320_0008, 0, 0, 0, 0, 1, 0, 0, 32'h0, 26'h0, 32'hFFFF_FFFC, 0);
      fetch(32'hFFFF_FFFC, 32'hAAAA_5555, 0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 0);
      fetch(32'h0000_0000, 32'h0BFF_FFFF, 5, 0, 1, 0, 0, 1, 0, 32'h0, 26'h3FF_FFFF, 32'h0, 0);
      fetch(32'h0FFF_FFFC, 32'h1234_5678, 0, 0, 0, 4, 0, 0, 1, 32'h0000_0001, 26'h0, 32'h0, 0);

      // reset while waiting for the response; a late response must be dropped
      exp_q.push_back(32'h1000_0004);
      wait_for_req();
      imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      step();
      rst = 1'b1;
      #3;
      check_reset_state("reset in wait");
      step();
      rst = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hBAD0_BAD0;
      step();
      step();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;

      fetch(RESET_PC, 32'h1111_2222, 0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0, 0);
      req_only(32'h0000_0004);

      check("leftover addr expectations", exp_q.size(), 32'd0);
      check("leftover instr expectations", exp_hold_q.size(), 32'd0);
      check("leftover misalign expectations", exp_mis_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
